// File: rtl/dmem_arbiter.sv
// Two-requester front end for the single-port data memory: core has priority,
// the debug master is guaranteed a win after MAX_WAIT consecutive denials.
package dmem_arbiter_pkg;
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_SB  = 4'd1,
        MEM_SH  = 4'd2,
        MEM_SW  = 4'd3,
        MEM_LB  = 4'd4,
        MEM_LH  = 4'd5,
        MEM_LW  = 4'd6,
        MEM_LBU = 4'd7,
        MEM_LHU = 4'd8
    } mem_op_t;
endpackage

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  mem_op_t     core_op,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_stall,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_req,
    input  mem_op_t     dbg_op,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        mem_wr_en,
    output mem_op_t     mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic {
        CORE_PRI  = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_t;

    function automatic logic is_aligned(input mem_op_t op, input logic [1:0] a);
        case (op)
            MEM_SH, MEM_LH, MEM_LHU: is_aligned = ~a[0];
            MEM_SW, MEM_LW:          is_aligned = (a == 2'b00);
            default:                 is_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_t op);
        is_load = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        is_store = op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            core_v, dbg_v;
    logic            core_gnt_c, dbg_gnt_c;
    mem_op_t         sel_op;
    logic [DW-1:0]   sel_addr, sel_wdata;
    logic            sel_ok;
    logic            core_rvalid_q, core_err_q, dbg_rvalid_q, dbg_err_q;
    logic [DW-1:0]   core_rdata_q, dbg_rdata_q;

    assign core_v = core_req & (core_op != MEM_NOP);
    assign dbg_v  = dbg_req & (dbg_op != MEM_NOP);

    // Arbiter state and starvation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CORE_PRI;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Grants are held off entirely while reset is asserted
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        core_gnt_c = 1'b0;
        dbg_gnt_c  = 1'b0;
        if (rst_n) begin
            case (state_q)
                CORE_PRI: begin
                    core_gnt_c = core_v;
                    dbg_gnt_c  = dbg_v & ~core_v;
                end
                DBG_FORCE: begin
                    dbg_gnt_c  = dbg_v;
                    core_gnt_c = core_v & ~dbg_v;
                end
                default: ;
            endcase
        end
        if (!dbg_v || dbg_gnt_c) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + CW'(1);
        end
        case (state_q)
            CORE_PRI:  if (dbg_v && !dbg_gnt_c && (wait_d == CW'(MAX_WAIT))) state_d = DBG_FORCE;
            DBG_FORCE: if (dbg_gnt_c || !dbg_v) state_d = CORE_PRI;
            default:   state_d = CORE_PRI;
        endcase
    end

    // Winner mux; a misaligned winner still burns its slot but touches nothing
    always_comb begin
        sel_op    = MEM_NOP;
        sel_addr  = '0;
        sel_wdata = '0;
        if (core_gnt_c) begin
            sel_op    = core_op;
            sel_addr  = core_addr;
            sel_wdata = core_wdata;
        end else if (dbg_gnt_c) begin
            sel_op    = dbg_op;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
        sel_ok    = is_aligned(sel_op, sel_addr[1:0]);
        mem_ctrl  = sel_ok ? sel_op : MEM_NOP;
        mem_wr_en = sel_ok & is_store(sel_op);
        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
    end

    // One-cycle completion response to whichever port won
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rvalid_q <= 1'b0;
            core_err_q    <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rvalid_q  <= 1'b0;
            dbg_err_q     <= 1'b0;
            dbg_rdata_q   <= '0;
        end else begin
            core_rvalid_q <= core_gnt_c;
            core_err_q    <= core_gnt_c & ~sel_ok;
            core_rdata_q  <= (core_gnt_c && sel_ok && is_load(sel_op)) ? mem_rdata : '0;
            dbg_rvalid_q  <= dbg_gnt_c;
            dbg_err_q     <= dbg_gnt_c & ~sel_ok;
            dbg_rdata_q   <= (dbg_gnt_c && sel_ok && is_load(sel_op)) ? mem_rdata : '0;
        end
    end

    assign core_gnt    = core_gnt_c;
    assign dbg_gnt     = dbg_gnt_c;
    assign core_stall  = rst_n & core_v & ~core_gnt_c;
    assign core_rvalid = core_rvalid_q;
    assign core_err    = core_err_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign dbg_err     = dbg_err_q;
    assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data_memory between two requesters: the pipeline MEM stage (core port) and the debug/program-loader master (dbg port).
- Arbitrates each cycle, with core priority bounded by a starvation counter.
- Checks alignment and drives data_memory's wr_en/mem_ctrl/addr/data_in.
- Returns registered read data and a completion strobe to the winning requester.
- Sits between the MEM stage/debug module and data_memory. The core stalls on core_stall.

Parameters:
MAX_WAIT, 4, cycles dbg may be denied consecutively before it is forced to win (1..15).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
core_req  in  1  core access request
core_op  in  mem_op_t  core memory op (MEM_SB..MEM_LHU)
core_addr  in  32  core byte address
core_wdata  in  32  core store data
core_gnt  out  1  combinational grant, same cycle as request
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  registered completion strobe
core_rdata  out  32  registered load data (0 for stores)
core_err  out  1  registered misalign error, valid with core_rvalid
dbg_req, dbg_op, dbg_addr, dbg_wdata  in  1/mem_op_t/32/32  same as core
dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  out  1/1/32/1  same as core
mem_wr_en  out  1  to data_memory wr_en
mem_ctrl  out  mem_op_t  to data_memory mem_ctrl
mem_addr  out  32  to data_memory addr
mem_wdata  out  32  to data_memory data_in
mem_rdata  in  32  from data_memory data_out (combinational read)

Behaviour:
- A request with op == MEM_NOP is treated as no request.
- Arbiter FSM has two states:
  - CORE_PRI (reset state): core wins if it requests; otherwise dbg wins if it requests.
  - DBG_FORCE: dbg wins if it requests, even over core.
- wait_cnt (4 bits, reset 0):
  - Increments when dbg requests and is not granted.
  - Clears when dbg is granted or dbg_req is low.
  - When it reaches MAX_WAIT while dbg is still requesting and denied, the FSM moves to DBG_FORCE on that edge.
- DBG_FORCE exits to CORE_PRI on a dbg grant, or when dbg_req drops. wait_cnt clears on exit.
- Grants are combinational and mutually exclusive (at most one per cycle). Memory outputs mux the winner's op, addr and wdata.
- When no port is granted: mem_ctrl = MEM_NOP, mem_wr_en = 0, mem_addr = 0, mem_wdata = 0.
- Alignment rules:
  - Halfword ops (SH/LH/LHU) require addr[0] = 0.
  - Word ops (SW/LW) require addr[1:0] = 0.
  - Byte ops are always aligned.
- Misaligned granted access:
  - Still consumes the grant, but mem_wr_en = 0 and mem_ctrl = MEM_NOP.
  - Next cycle: *_rvalid = 1, *_err = 1, *_rdata = 0.
- Aligned granted store: mem_wr_en = 1 in the grant cycle, so memory writes at the end of that cycle. Next cycle: rvalid = 1, err = 0, rdata = 0.
- Aligned granted load: mem_rdata is sampled at the end of the grant cycle. Next cycle: rvalid = 1, rdata = sampled value, err = 0.
- Latency: exactly 1 cycle from grant to rvalid. rvalid is a one-cycle pulse per grant.
- Back-to-back grants to the same port give consecutive rvalid pulses. The port sustains 1 access per cycle.
- The losing port holds req/op/addr/wdata stable until granted. The arbiter does not latch requests.
- Reset (rst_n = 0 at an edge):
  - State → CORE_PRI, wait_cnt → 0.
  - All rvalid/err → 0, rdata → 0.
  - Grants are forced to 0 while rst_n = 0, so no write reaches memory during reset.
  - An access granted in the cycle reset is asserted produces no rvalid.

Test Plan:
1. Core SW addr 100 data 89ABCDEF; one cycle later core LW 100 → core_gnt both cycles; LW core_rvalid next cycle with core_rdata = 89ABCDEF, core_err = 0.
2. Dbg LBU addr 100 while idle → dbg_gnt same cycle; next cycle dbg_rdata = 000000EF. Dbg LH addr 102 → FFFF89AB.
3. Core LW addr 102 → core_err = 1 with core_rvalid next cycle, mem_wr_en never 1. A following core SW addr 101 must leave LW 100 reading unchanged (89ABCDEF).
4. Core and dbg both requesting continuously, MAX_WAIT = 4:
   - Core is granted cycles 0–3 and dbg is granted at cycle 4, then core resumes.
   - Over 20 cycles the pattern repeats, with dbg winning every 5th cycle.
   - core_stall = 1 exactly in the dbg-grant cycles.
5. Dbg waits 2 cycles then drops dbg_req → wait_cnt clears. Re-requesting dbg against a busy core again waits 4 cycles.
6. Assert rst_n = 0 during a granted core SW addr 200 data 12345678:
   - No memory write and core_rvalid = 0 after reset.
   - Subsequent core LW 200 returns the pre-reset memory contents.
   - All outputs are 0 during reset.
